apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_pkg.sv | 18 +
 rtl/apb_wait_timer.sv | 38 +++
 rtl/apb_master.sv | 128 ++++++++++++
 tb/tb_apb_master.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared state type, default sizing and helpers for the APB master.
package apb_pkg;

  localparam int APB_ADDR_W      = 8;
  localparam int APB_DATA_W      = 8;
  localparam int APB_TIMEOUT_CYC = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Counts pready-low ACCESS cycles; expired flags the last permitted wait cycle.
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYC = APB_TIMEOUT_CYC
) (
  input  logic pclk,
  input  logic prst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYC - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // This wait cycle brings the count to TIMEOUT_CYC, so the transfer aborts on this edge.
  assign expired_o = enable_i && (cnt_q == LAST_WAIT);

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB master: one command in, one APB transfer, one response pulse.
//   state  | meaning
//   IDLE   | req_ready high, bus idle, last address/data retained
//   SETUP  | psel high, penable low, one cycle
//   ACCESS | psel and penable high until pready or timeout
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int TIMEOUT_CYC = APB_TIMEOUT_CYC
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [7:0]        err_cnt,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  apb_state_e        state_q;
  logic              psel_q, penable_q, pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              rsp_valid_q, rsp_err_q, rsp_timeout_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic              wait_expired;

  assign err_cnt_d = sat_inc8(err_cnt_q);

  apb_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wait_timer (
    .pclk      (pclk),
    .prst      (prst),
    .clear_i   (state_q == SETUP),
    .enable_i  ((state_q == ACCESS) && !pready),
    .expired_o (wait_expired)
  );

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      state_q       <= IDLE;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
      err_cnt_q     <= '0;
    end else begin
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            state_q  <= SETUP;
            psel_q   <= 1'b1;
            pwrite_q <= req_write;
            paddr_q  <= req_addr;
            pwdata_q <= req_write ? req_wdata : '0;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          if (pready) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= pslverr;
            rsp_rdata_q <= (!pwrite_q && !pslverr) ? prdata : '0;
            if (pslverr) begin
              err_cnt_q <= err_cnt_d;
            end
          end else if (wait_expired) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_err_q     <= 1'b1;
            rsp_timeout_q <= 1'b1;
            rsp_rdata_q   <= '0;
            err_cnt_q     <= err_cnt_d;
          end
        end
        default: begin
          state_q   <= IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign pwrite      = pwrite_q;
  assign paddr       = paddr_q;
  assign pwdata      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed and randomized transfers for apb_master, checked against a transaction-level model.
module tb_apb_master;

  localparam int TMO = 16;

  logic       pclk, prst;
  logic       req_valid, req_ready, req_write;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid, rsp_err, rsp_timeout;
  logic [7:0] rsp_rdata, err_cnt;
  logic       psel, penable, pwrite;
  logic [7:0] paddr, pwdata, prdata;
  logic       pready, pslverr;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] err_model  = 8'd0;
  logic [7:0] last_rdata = 8'd0;

  apb_master dut (
    .pclk        (pclk),
    .prst        (prst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .err_cnt     (err_cnt),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .pslverr     (pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic noise_req();
    req_valid = 1'($urandom);
    req_write = 1'($urandom);
    req_addr  = 8'($urandom);
    req_wdata = 8'($urandom);
  endtask

  // One full transfer starting from an IDLE cycle; slave holds pready low for 'waits' cycles.
  task automatic do_xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                         input int waits, input logic serr, input logic [7:0] rd);
    int         n_access;
    logic       timed_out;
    logic [7:0] exp_pwdata, exp_rdata;
    logic       exp_err;
    n_access   = (waits < TMO) ? waits + 1 : TMO;
    timed_out  = (waits >= TMO);
    exp_pwdata = wr ? wd : 8'h00;

    chk("idle_req_ready", req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    pready = 1'($urandom); pslverr = 1'($urandom); prdata = 8'($urandom);
    tick();

    chk("setup_psel", psel, 1);
    chk("setup_penable", penable, 0);
    chk("setup_pwrite", pwrite, wr);
    chk("setup_paddr", paddr, addr);
    chk("setup_pwdata", pwdata, exp_pwdata);
    chk("setup_req_ready", req_ready, 0);
    chk("setup_rsp_valid", rsp_valid, 0);
    chk("setup_rsp_rdata_hold", rsp_rdata, last_rdata);
    noise_req();
    pready = 1'($urandom); pslverr = 1'($urandom); prdata = 8'($urandom);
    tick();

    for (int i = 0; i < n_access; i++) begin
      chk("access_psel", psel, 1);
      chk("access_penable", penable, 1);
      chk("access_pwrite", pwrite, wr);
      chk("access_paddr", paddr, addr);
      chk("access_pwdata", pwdata, exp_pwdata);
      chk("access_req_ready", req_ready, 0);
      chk("access_rsp_valid", rsp_valid, 0);
      noise_req();
      pready  = (i == waits);
      pslverr = (i == waits) ? serr : 1'($urandom);
      prdata  = (i == waits) ? rd : 8'($urandom);
      tick();
    end

    exp_err   = timed_out ? 1'b1 : serr;
    exp_rdata = (!timed_out && !wr && !serr) ? rd : 8'h00;
    if (exp_err) err_model = (err_model < 8'd255) ? err_model + 8'd1 : 8'd255;
    last_rdata = exp_rdata;

    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_err", rsp_err, exp_err);
    chk("rsp_timeout", rsp_timeout, timed_out);
    chk("rsp_rdata", rsp_rdata, exp_rdata);
    chk("err_cnt", err_cnt, err_model);
    chk("rsp_psel", psel, 0);
    chk("rsp_penable", penable, 0);
    chk("rsp_req_ready", req_ready, 1);
    chk("idle_paddr_hold", paddr, addr);
    chk("idle_pwdata_hold", pwdata, exp_pwdata);
    req_valid = 1'b0;
  endtask

  task automatic idle_gap(input int n);
    req_valid = 1'b0;
    for (int g = 0; g < n; g++) begin
      pready = 1'($urandom); pslverr = 1'($urandom);
      tick();
      chk("gap_rsp_valid", rsp_valid, 0);
      chk("gap_rsp_err", rsp_err, 0);
      chk("gap_rsp_rdata_hold", rsp_rdata, last_rdata);
      chk("gap_psel", psel, 0);
    end
  endtask

  initial begin
    int start_cyc;
    prst = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    prdata = 8'h00; pready = 1'b0; pslverr = 1'b0;
    tick();
    tick();
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_err_cnt", err_cnt, 0);
    prst = 1'b1;
    chk("rel_req_ready", req_ready, 1);
    tick();
    chk("rel_req_ready_cyc1", req_ready, 1);

    // Directed scenarios: zero-wait write, 3-wait read, slave error, timeout boundaries.
    do_xfer(1'b1, 8'h10, 8'hA5, 0, 1'b0, 8'h00);
    idle_gap(1);
    do_xfer(1'b0, 8'h10, 8'h00, 3, 1'b0, 8'hA5);
    chk("read_rdata_a5", rsp_rdata, 8'hA5);
    idle_gap(1);
    do_xfer(1'b0, 8'hC9, 8'h00, 0, 1'b1, 8'h77);
    chk("slverr_err_cnt_1", err_cnt, 8'd1);
    idle_gap(1);
    do_xfer(1'b0, 8'h22, 8'h00, TMO - 1, 1'b0, 8'h3C);
    idle_gap(1);
    do_xfer(1'b1, 8'h44, 8'h99, TMO, 1'b0, 8'h00);
    chk("timeout_flag", rsp_timeout, 1);
    chk("timeout_err_cnt_2", err_cnt, 8'd2);

    // Back-to-back: four zero-wait transfers, accept overlaps each response cycle.
    start_cyc = cyc;
    for (int k = 0; k < 4; k++) begin
      do_xfer(1'($urandom), 8'($urandom), 8'($urandom), 0, 1'b0, 8'($urandom));
    end
    chk("b2b_cycles", cyc - start_cyc, 12);

    for (int k = 0; k < 40; k++) begin
      do_xfer(1'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 20),
              1'($urandom), 8'($urandom));
      if ($urandom_range(0, 1) == 1) idle_gap($urandom_range(1, 2));
    end

    // Reset asserted mid-ACCESS.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h3C; req_wdata = 8'h5A;
    tick();
    req_valid = 1'b0; pready = 1'b0;
    tick();
    chk("pre_rst_penable", penable, 1);
    #2 prst = 1'b0;
    #1;
    chk("async_rst_psel", psel, 0);
    chk("async_rst_penable", penable, 0);
    chk("async_rst_rsp_valid", rsp_valid, 0);
    chk("async_rst_paddr", paddr, 0);
    chk("async_rst_err_cnt", err_cnt, 0);
    tick();
    chk("in_rst_rsp_valid", rsp_valid, 0);
    prst = 1'b1;
    err_model = 8'd0;
    last_rdata = 8'd0;
    chk("post_rst_req_ready", req_ready, 1);
    tick();
    chk("post_rst_rsp_valid", rsp_valid, 0);
    chk("post_rst_psel", psel, 0);
    chk("post_rst_req_ready_cyc1", req_ready, 1);

    // Saturation: 300 error completions.
    for (int k = 0; k < 300; k++) begin
      do_xfer(1'($urandom), 8'($urandom), 8'($urandom), 0, 1'b1, 8'($urandom));
    end
    chk("err_cnt_saturated", err_cnt, 8'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
